lsu_data_port: RTL
==================

# lsu_data_port

Load/store unit sitting directly downstream of the ALU in the RV32I datapath. It takes the ALU's computed effective address plus rs2 store data and funct3. It runs one data-memory transaction over a req/ready handshake and returns sign- or zero-extended load data to writeback. It also flags misaligned accesses, illegal size encodings and bus timeouts; the core stalls on `busy`.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles `mem_req` may wait for `mem_ready` before abort; legal range 1..255.

Ports:
- `clk` in 1: core clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: start a transaction; sampled only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V size/sign field.
- `req_addr` in 32: effective address, the ALU result.
- `req_wdata` in 32: store data (rs2).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `load_data` out 32: extended load result, valid when `done` and held until the next `done`.
- `err_misalign` out 1: valid with `done`.
- `err_illegal` out 1: valid with `done`.
- `err_bus` out 1: valid with `done`.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte-lane write strobes; 0 for loads.
- `mem_wdata` out 32: lane-positioned store data.
- `mem_rdata` in 32: read data, sampled when `mem_ready` is high.
- `mem_ready` in 1: memory accepts or completes the request.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE + `req_valid`: latch the request and decode funct3.
  - Illegal: load funct3 in {011,110,111}, or store funct3 not in {000,001,010}. Go to DONE with `err_illegal`=1; no `mem_req`.
  - Misaligned: half with `addr[0]`=1, or word with `addr[1:0]`≠0. Go to DONE with `err_misalign`=1; no `mem_req`.
  - Otherwise go to ACCESS with `mem_req`=1.
- ACCESS: hold `mem_req` and all `mem_*` outputs stable until `mem_ready` is sampled high.
  - On that edge, capture `mem_rdata` (loads) and go to DONE.
  - Wait counter increments each ACCESS cycle with `mem_ready` low. On reaching `TIMEOUT`, drop `mem_req`, go to DONE with `err_bus`=1, and leave `load_data` unchanged.
- DONE: `done`=1 for exactly one cycle, then IDLE. Error flags are zero in all other cycles.
- Store lanes, with `o`=`addr[1:0]`:
  - SB: `wdata`={4{b[7:0]}}, `wstrb`=0001<<o.
  - SH: `wdata`={2{b[15:0]}}, `wstrb`=0011<<o.
  - SW: `wdata`=b, `wstrb`=1111.
- Load extraction: byte = `rdata[8*o+:8]`, half = `rdata[8*o+:16]`.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- `req_valid` while `busy`: ignored, not queued.

## Timing
- Reset (async assert): state IDLE; counter 0; all outputs 0, including `load_data` and `mem_*`. `mem_req` falls immediately even mid-ACCESS, and the memory must tolerate the abandoned request.
- Reset release: first accepted request is on the first rising edge with `rst_n`=1.
- Request accepted at edge E0: `mem_req` high from E0 until the edge where `mem_ready` is sampled.
- Zero-wait access: `mem_ready` high in the first ACCESS cycle, `done` in the cycle after E1. Start-to-done = 2 cycles.
- N wait cycles: start-to-done = 2+N.
- Error path (illegal/misalign): `done` in the cycle immediately after E0 (1 cycle).
- Timeout: `done`/`err_bus` = `TIMEOUT`+1 cycles after E0.
- Back-to-back: a new request is accepted in IDLE the cycle after DONE, so sustained throughput is 1 access per 3 cycles.
- Priority: illegal over misalign when both apply.

## Test plan
- LW `addr`=0x1004, `mem_rdata`=0xDEADBEEF, `mem_ready` high in the first ACCESS cycle -> `mem_addr`=0x1004, `mem_wstrb`=0000, `done` 2 cycles after accept, `load_data`=0xDEADBEEF, no errors.
- LB/LBU `addr`=0x2003, `rdata`=0x80FF7F01 -> LB gives 0xFFFFFF80 and LBU gives 0x00000080. LH `addr`=0x2002 gives 0xFFFF80FF.
- SH `addr`=0x3002, `wdata`=0x0000ABCD, 3 wait cycles -> `mem_wdata`=0xABCDABCD, `mem_wstrb`=1100 held stable 4 cycles, `done` 5 cycles after accept.
- LW `addr`=0x1001 -> `err_misalign`=1 with `done` 1 cycle after accept, `mem_req` never high. Store funct3=011 -> `err_illegal`=1.
- `TIMEOUT`=4, `mem_ready` tied low -> `mem_req` high for 4 cycles then low, `err_bus`+`done` at cycle 5, `load_data` unchanged.
- `rst_n` pulsed low mid-ACCESS -> `mem_req`/`busy` drop without a clock. A new `req_valid` after release is accepted normally; `req_valid` asserted during `busy` produces no extra `done`.

Source files
------------

// File: rtl/lsu_data_port_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// One request is outstanding at a time; mem_ready both accepts and completes it.
interface lsu_data_port_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/lsu_data_port.sv
// RV32I load/store unit: one data-memory transaction per request, with lane
// placement for stores, sign/zero extension for loads and error reporting.
module lsu_data_port #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            busy,
  output logic            done,
  output logic [31:0]     load_data,
  output logic            err_misalign,
  output logic            err_illegal,
  output logic            err_bus,
  lsu_data_port_if.master mem
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_misalign_reg;
  logic        err_illegal_reg;
  logic        err_bus_reg;
  logic [31:0] load_data_reg;
  logic        mem_req_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [3:0]  mem_wstrb_reg;
  logic [31:0] mem_wdata_reg;

  logic [1:0]  req_size;
  logic [1:0]  req_offset;
  logic        req_illegal;
  logic        req_misalign;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;

  assign req_size   = req_funct3[1:0];
  assign req_offset = req_addr[1:0];

  // Loads allow B/H/W plus the unsigned B/H forms; stores only B/H/W.
  assign req_illegal = req_we ? (req_funct3[2] || (req_size == 2'b11))
                              : ((req_size == 2'b11) || (req_funct3 == 3'b110));

  assign req_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_offset != 2'b00));

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_wdata[8*gi +: 8] =
        (req_size == 2'b00) ? req_wdata[7:0] :
        (req_size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                              req_wdata[8*gi +: 8];

    assign lane_wstrb[gi] =
        (req_size == 2'b00) ? (req_offset == 2'(gi)) :
        (req_size == 2'b01) ? (req_offset[1] == 1'(gi/2)) :
                              1'b1;
  end

  // Lane selection for loads uses the offset latched at accept time.
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] load_ext;

  assign rd_half = offset_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
  assign rd_byte = offset_reg[0] ? rd_half[15:8] : rd_half[7:0];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      wait_cnt_reg     <= 8'd0;
      funct3_reg       <= 3'd0;
      offset_reg       <= 2'd0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      err_misalign_reg <= 1'b0;
      err_illegal_reg  <= 1'b0;
      err_bus_reg      <= 1'b0;
      load_data_reg    <= 32'd0;
      mem_req_reg      <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= 32'd0;
      mem_wstrb_reg    <= 4'd0;
      mem_wdata_reg    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            funct3_reg <= req_funct3;
            offset_reg <= req_offset;
            busy_reg   <= 1'b1;
            if (req_illegal) begin
              state_reg       <= DONE;
              done_reg        <= 1'b1;
              err_illegal_reg <= 1'b1;
            end else if (req_misalign) begin
              state_reg        <= DONE;
              done_reg         <= 1'b1;
              err_misalign_reg <= 1'b1;
            end else begin
              state_reg     <= ACCESS;
              wait_cnt_reg  <= 8'd0;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= req_we;
              mem_addr_reg  <= {req_addr[31:2], 2'b00};
              mem_wstrb_reg <= req_we ? lane_wstrb : 4'd0;
              mem_wdata_reg <= lane_wdata;
            end
          end
        end

        ACCESS: begin
          if (mem.mem_ready) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            mem_req_reg <= 1'b0;
            if (!mem_we_reg) begin
              load_data_reg <= load_ext;
            end
          end else if (wait_cnt_reg == LAST_WAIT) begin
            // Abort: load_data keeps the previous result.
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            err_bus_reg <= 1'b1;
            mem_req_reg <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        DONE: begin
          state_reg        <= IDLE;
          busy_reg         <= 1'b0;
          done_reg         <= 1'b0;
          err_misalign_reg <= 1'b0;
          err_illegal_reg  <= 1'b0;
          err_bus_reg      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign load_data     = load_data_reg;
  assign err_misalign  = err_misalign_reg;
  assign err_illegal   = err_illegal_reg;
  assign err_bus       = err_bus_reg;
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wstrb = mem_wstrb_reg;
  assign mem.mem_wdata = mem_wdata_reg;
endmodule
